// File: rtl/trap_arbiter.sv
// M-stage trap arbiter: picks the highest-priority interrupt/exception, computes cause and delegation,
// and runs the WFI stall machine. Define TRAP_CAUSE_HISTORY_EN to keep a ring of recent trap causes.
module trap_arbiter #(
  parameter int XLEN        = 64,
  parameter bit S_SUPPORTED = 1'b1,
  parameter int HIST_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    StallW,
  input  logic                    FlushW,
  input  logic                    InstrValidM,
  input  logic                    IllegalInstrFaultM,
  input  logic                    EcallFaultM,
  input  logic                    BreakpointFaultM,
  input  logic                    RetM,
  input  logic                    wfiM,
  input  logic                    InstrPageFaultM,
  input  logic                    InstrAccessFaultM,
  input  logic                    LoadMisalignedFaultM,
  input  logic                    StoreMisalignedFaultM,
  input  logic                    LoadAccessFaultM,
  input  logic                    StoreAccessFaultM,
  input  logic [11:0]             MIP,
  input  logic [11:0]             MIE,
  input  logic [11:0]             MIDELEG,
  input  logic [15:0]             MEDELEG,
  input  logic                    STATUS_MIE,
  input  logic                    STATUS_SIE,
  input  logic [1:0]              PrivilegeModeW,
  output logic                    TrapM,
  output logic                    InterruptM,
  output logic                    DelegateM,
  output logic [3:0]              CauseM,
  output logic [XLEN-1:0]         CauseW,
  output logic                    WFIStallM,
  output logic [5*HIST_DEPTH-1:0] HistCause
);

  // state | meaning
  // RUN   | normal execution
  // WAIT  | WFI retired, pipeline stalled until a pending interrupt or flush
  // WAKE  | one-cycle release; an enabled interrupt is taken here
  typedef enum logic [1:0] {RUN, WAIT, WAKE} wfiState_t;

  wfiState_t   state;
  logic [11:0] PendQ;
  logic [11:0] delegMask, intEnMask, intReady;
  logic        mEn, sEn, intAny, excAny, wfiAccept;
  logic [3:0]  intCause, excCause;
  logic [15:0] midelegExt;

  assign delegMask  = MIDELEG & {12{S_SUPPORTED}};
  assign mEn        = (PrivilegeModeW != 2'd3) | STATUS_MIE;
  assign sEn        = (PrivilegeModeW == 2'd0) | ((PrivilegeModeW == 2'd1) & STATUS_SIE);
  assign intEnMask  = (~delegMask & {12{mEn}}) | (delegMask & {12{sEn}});
  // Interrupts are held off while parked in WAIT and taken in WAKE.
  assign intReady   = PendQ & intEnMask & {12{state != WAIT}};
  assign midelegExt = {4'b0000, MIDELEG};

  always_comb begin
    intAny   = 1'b1;
    intCause = 4'd0;
    if (intReady[11])     intCause = 4'd11;
    else if (intReady[3]) intCause = 4'd3;
    else if (intReady[7]) intCause = 4'd7;
    else if (intReady[9]) intCause = 4'd9;
    else if (intReady[1]) intCause = 4'd1;
    else if (intReady[5]) intCause = 4'd5;
    else                  intAny   = 1'b0;
  end

  always_comb begin
    excAny   = InstrValidM;
    excCause = 4'd0;
    if (!InstrValidM)               excAny   = 1'b0;
    else if (InstrPageFaultM)       excCause = 4'd12;
    else if (InstrAccessFaultM)     excCause = 4'd1;
    else if (IllegalInstrFaultM)    excCause = 4'd2;
    else if (BreakpointFaultM)      excCause = 4'd3;
    else if (EcallFaultM)           excCause = 4'd8 + {2'b00, PrivilegeModeW};
    else if (StoreMisalignedFaultM) excCause = 4'd6;
    else if (LoadMisalignedFaultM)  excCause = 4'd4;
    else if (StoreAccessFaultM)     excCause = 4'd7;
    else if (LoadAccessFaultM)      excCause = 4'd5;
    else                            excAny   = 1'b0;
  end

  assign TrapM      = intAny | excAny;
  assign InterruptM = intAny;
  assign CauseM     = intAny ? intCause : excCause;
  assign DelegateM  = S_SUPPORTED & TrapM & (PrivilegeModeW != 2'd3) &
                      (intAny ? midelegExt[CauseM] : MEDELEG[CauseM]);
  // The decoder never flags wfi and a return together; the return wins if it ever did.
  assign wfiAccept  = wfiM & ~RetM & InstrValidM & ~TrapM & ~StallW;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      WFIStallM <= 1'b0;
      PendQ     <= '0;
      CauseW    <= '0;
    end else begin
      PendQ <= MIP & MIE;
      case (state)
        RUN: if (wfiAccept) begin
          state     <= WAIT;
          WFIStallM <= 1'b1;
        end
        WAIT: if ((|PendQ) | FlushW) begin
          state     <= WAKE;
          WFIStallM <= 1'b0;
        end
        default: begin
          state     <= RUN;
          WFIStallM <= 1'b0;
        end
      endcase
      if (TrapM & ~StallW) CauseW <= {InterruptM, {(XLEN-5){1'b0}}, CauseM};
    end
  end

`ifdef TRAP_CAUSE_HISTORY_EN
  logic [5*HIST_DEPTH-1:0] histQ;

  always_ff @(posedge clk) begin
    if (!reset)                histQ <= '0;
    else if (TrapM & ~StallW)  histQ <= {histQ[5*HIST_DEPTH-6:0], InterruptM, CauseM};
  end

  assign HistCause = histQ;
`else
  assign HistCause = '0;
`endif

endmodule
